stream_split: RTL and testbench

- Inverse of the lane-concatenation block: takes one 96-bit AXI-Stream word and fans it out as twelve independent 8-bit AXI-Stream masters, lane nn carrying bits [8*nn+7:8*nn].
- Each lane has a one-deep output register with full TVALID/TREADY handshaking.
- An input word is accepted only when every enabled lane can take its byte in the same cycle, so all lanes stay word-aligned.
- Sits between a wide producer (DMA/FIFO) and per-channel byte consumers.

---
 rtl/stream_split.sv | 131 +++++++++++++
 tb/tb_stream_split.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/stream_split.sv
// stream_split: fans one 96-bit AXI-Stream word out to twelve 8-bit AXI-Stream lanes.
// Each lane has a one-deep output register; words are accepted only when every enabled lane can load.
module stream_split #(
  parameter logic [11:0] LANE_MASK   = 12'hFFF,
  parameter int          COUNT_WIDTH = 32
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic [95:0]            S_AXIS_TDATA,
  input  logic                   S_AXIS_TVALID,
  output logic                   S_AXIS_TREADY,
  output logic [7:0]             M_AXIS_00_TDATA,
  output logic                   M_AXIS_00_TVALID,
  input  logic                   M_AXIS_00_TREADY,
  output logic [7:0]             M_AXIS_01_TDATA,
  output logic                   M_AXIS_01_TVALID,
  input  logic                   M_AXIS_01_TREADY,
  output logic [7:0]             M_AXIS_02_TDATA,
  output logic                   M_AXIS_02_TVALID,
  input  logic                   M_AXIS_02_TREADY,
  output logic [7:0]             M_AXIS_03_TDATA,
  output logic                   M_AXIS_03_TVALID,
  input  logic                   M_AXIS_03_TREADY,
  output logic [7:0]             M_AXIS_04_TDATA,
  output logic                   M_AXIS_04_TVALID,
  input  logic                   M_AXIS_04_TREADY,
  output logic [7:0]             M_AXIS_05_TDATA,
  output logic                   M_AXIS_05_TVALID,
  input  logic                   M_AXIS_05_TREADY,
  output logic [7:0]             M_AXIS_06_TDATA,
  output logic                   M_AXIS_06_TVALID,
  input  logic                   M_AXIS_06_TREADY,
  output logic [7:0]             M_AXIS_07_TDATA,
  output logic                   M_AXIS_07_TVALID,
  input  logic                   M_AXIS_07_TREADY,
  output logic [7:0]             M_AXIS_08_TDATA,
  output logic                   M_AXIS_08_TVALID,
  input  logic                   M_AXIS_08_TREADY,
  output logic [7:0]             M_AXIS_09_TDATA,
  output logic                   M_AXIS_09_TVALID,
  input  logic                   M_AXIS_09_TREADY,
  output logic [7:0]             M_AXIS_10_TDATA,
  output logic                   M_AXIS_10_TVALID,
  input  logic                   M_AXIS_10_TREADY,
  output logic [7:0]             M_AXIS_11_TDATA,
  output logic                   M_AXIS_11_TVALID,
  input  logic                   M_AXIS_11_TREADY,
  output logic [COUNT_WIDTH-1:0] word_count,
  output logic [11:0]            lanes_busy
);

  localparam int LANES = 12;

  logic             rdy_en;
  logic [LANES-1:0] m_ready;
  logic [LANES-1:0] vld_q;
  logic [LANES-1:0] free;
  logic [7:0]       data_q [LANES];
  logic             accept;

  assign m_ready = {M_AXIS_11_TREADY, M_AXIS_10_TREADY, M_AXIS_09_TREADY, M_AXIS_08_TREADY,
                    M_AXIS_07_TREADY, M_AXIS_06_TREADY, M_AXIS_05_TREADY, M_AXIS_04_TREADY,
                    M_AXIS_03_TREADY, M_AXIS_02_TREADY, M_AXIS_01_TREADY, M_AXIS_00_TREADY};

  // A lane can take a new byte if it is disabled, empty, or handing its byte off this cycle.
  assign free          = ~LANE_MASK | ~vld_q | m_ready;
  assign S_AXIS_TREADY = rdy_en & (&free);
  assign accept        = S_AXIS_TVALID & S_AXIS_TREADY;

  // Holds off the input for one cycle after reset release so the first accept sees settled state.
  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  // NOTE: data_q is reset because lane TDATA must read 0 out of reset; a pure datapath array
  // would normally be left unreset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      vld_q <= '0;
      for (int n = 0; n < LANES; n++) data_q[n] <= 8'h00;
    end else begin
      for (int n = 0; n < LANES; n++) begin
        if (LANE_MASK[n]) begin
          // A load on the same edge as a handshake wins, keeping the lane full without a bubble.
          if (accept) begin
            vld_q[n]  <= 1'b1;
            data_q[n] <= S_AXIS_TDATA[8*n +: 8];
          end else if (m_ready[n]) begin
            vld_q[n] <= 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)    word_count <= '0;
    else if (accept) word_count <= word_count + COUNT_WIDTH'(1);
  end

  assign lanes_busy = vld_q;

  assign M_AXIS_00_TDATA = data_q[0];
  assign M_AXIS_01_TDATA = data_q[1];
  assign M_AXIS_02_TDATA = data_q[2];
  assign M_AXIS_03_TDATA = data_q[3];
  assign M_AXIS_04_TDATA = data_q[4];
  assign M_AXIS_05_TDATA = data_q[5];
  assign M_AXIS_06_TDATA = data_q[6];
  assign M_AXIS_07_TDATA = data_q[7];
  assign M_AXIS_08_TDATA = data_q[8];
  assign M_AXIS_09_TDATA = data_q[9];
  assign M_AXIS_10_TDATA = data_q[10];
  assign M_AXIS_11_TDATA = data_q[11];

  assign M_AXIS_00_TVALID = vld_q[0];
  assign M_AXIS_01_TVALID = vld_q[1];
  assign M_AXIS_02_TVALID = vld_q[2];
  assign M_AXIS_03_TVALID = vld_q[3];
  assign M_AXIS_04_TVALID = vld_q[4];
  assign M_AXIS_05_TVALID = vld_q[5];
  assign M_AXIS_06_TVALID = vld_q[6];
  assign M_AXIS_07_TVALID = vld_q[7];
  assign M_AXIS_08_TVALID = vld_q[8];
  assign M_AXIS_09_TVALID = vld_q[9];
  assign M_AXIS_10_TVALID = vld_q[10];
  assign M_AXIS_11_TVALID = vld_q[11];

endmodule

// File: tb/tb_stream_split.sv
// Bench for stream_split: a full-mask 32-bit-count instance and a 4-lane 4-bit-count instance,
// both driven from one stimulus stream and checked against per-lane byte queues.
module tb_stream_split;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic [95:0] s_tdata = '0;
  logic        s_tvalid = 1'b0;
  logic [11:0] a_rdy = 12'hFFF;
  logic [11:0] b_rdy = 12'hFFF;

  wire         a_trdy, b_trdy;
  wire  [7:0]  a_td [12];
  wire  [7:0]  b_td [12];
  wire  [11:0] a_tv, b_tv, a_busy, b_busy;
  wire  [31:0] a_cnt;
  wire  [3:0]  b_cnt;

  int checks = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  stream_split #(.LANE_MASK(12'hFFF), .COUNT_WIDTH(32)) dut_a (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(a_trdy),
    .M_AXIS_00_TDATA(a_td[0]),  .M_AXIS_00_TVALID(a_tv[0]),  .M_AXIS_00_TREADY(a_rdy[0]),
    .M_AXIS_01_TDATA(a_td[1]),  .M_AXIS_01_TVALID(a_tv[1]),  .M_AXIS_01_TREADY(a_rdy[1]),
    .M_AXIS_02_TDATA(a_td[2]),  .M_AXIS_02_TVALID(a_tv[2]),  .M_AXIS_02_TREADY(a_rdy[2]),
    .M_AXIS_03_TDATA(a_td[3]),  .M_AXIS_03_TVALID(a_tv[3]),  .M_AXIS_03_TREADY(a_rdy[3]),
    .M_AXIS_04_TDATA(a_td[4]),  .M_AXIS_04_TVALID(a_tv[4]),  .M_AXIS_04_TREADY(a_rdy[4]),
    .M_AXIS_05_TDATA(a_td[5]),  .M_AXIS_05_TVALID(a_tv[5]),  .M_AXIS_05_TREADY(a_rdy[5]),
    .M_AXIS_06_TDATA(a_td[6]),  .M_AXIS_06_TVALID(a_tv[6]),  .M_AXIS_06_TREADY(a_rdy[6]),
    .M_AXIS_07_TDATA(a_td[7]),  .M_AXIS_07_TVALID(a_tv[7]),  .M_AXIS_07_TREADY(a_rdy[7]),
    .M_AXIS_08_TDATA(a_td[8]),  .M_AXIS_08_TVALID(a_tv[8]),  .M_AXIS_08_TREADY(a_rdy[8]),
    .M_AXIS_09_TDATA(a_td[9]),  .M_AXIS_09_TVALID(a_tv[9]),  .M_AXIS_09_TREADY(a_rdy[9]),
    .M_AXIS_10_TDATA(a_td[10]), .M_AXIS_10_TVALID(a_tv[10]), .M_AXIS_10_TREADY(a_rdy[10]),
    .M_AXIS_11_TDATA(a_td[11]), .M_AXIS_11_TVALID(a_tv[11]), .M_AXIS_11_TREADY(a_rdy[11]),
    .word_count(a_cnt), .lanes_busy(a_busy)
  );

  stream_split #(.LANE_MASK(12'h00F), .COUNT_WIDTH(4)) dut_b (
    .aclk(aclk), .aresetn(aresetn),
    .S_AXIS_TDATA(s_tdata), .S_AXIS_TVALID(s_tvalid), .S_AXIS_TREADY(b_trdy),
    .M_AXIS_00_TDATA(b_td[0]),  .M_AXIS_00_TVALID(b_tv[0]),  .M_AXIS_00_TREADY(b_rdy[0]),
    .M_AXIS_01_TDATA(b_td[1]),  .M_AXIS_01_TVALID(b_tv[1]),  .M_AXIS_01_TREADY(b_rdy[1]),
    .M_AXIS_02_TDATA(b_td[2]),  .M_AXIS_02_TVALID(b_tv[2]),  .M_AXIS_02_TREADY(b_rdy[2]),
    .M_AXIS_03_TDATA(b_td[3]),  .M_AXIS_03_TVALID(b_tv[3]),  .M_AXIS_03_TREADY(b_rdy[3]),
    .M_AXIS_04_TDATA(b_td[4]),  .M_AXIS_04_TVALID(b_tv[4]),  .M_AXIS_04_TREADY(b_rdy[4]),
    .M_AXIS_05_TDATA(b_td[5]),  .M_AXIS_05_TVALID(b_tv[5]),  .M_AXIS_05_TREADY(b_rdy[5]),
    .M_AXIS_06_TDATA(b_td[6]),  .M_AXIS_06_TVALID(b_tv[6]),  .M_AXIS_06_TREADY(b_rdy[6]),
    .M_AXIS_07_TDATA(b_td[7]),  .M_AXIS_07_TVALID(b_tv[7]),  .M_AXIS_07_TREADY(b_rdy[7]),
    .M_AXIS_08_TDATA(b_td[8]),  .M_AXIS_08_TVALID(b_tv[8]),  .M_AXIS_08_TREADY(b_rdy[8]),
    .M_AXIS_09_TDATA(b_td[9]),  .M_AXIS_09_TVALID(b_tv[9]),  .M_AXIS_09_TREADY(b_rdy[9]),
    .M_AXIS_10_TDATA(b_td[10]), .M_AXIS_10_TVALID(b_tv[10]), .M_AXIS_10_TREADY(b_rdy[10]),
    .M_AXIS_11_TDATA(b_td[11]), .M_AXIS_11_TVALID(b_tv[11]), .M_AXIS_11_TREADY(b_rdy[11]),
    .word_count(b_cnt), .lanes_busy(b_busy)
  );

  // Reference model: one queue of undelivered bytes per lane per instance (index i*12+n).
  logic [7:0]  lq [24][$];
  logic [31:0] mcnt [2];
  bit          mrdy_en [2];
  logic [11:0] mmask [2];
  logic [31:0] cmask [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 24; k++) lq[k].delete();
    for (int i = 0; i < 2; i++) begin
      mcnt[i]    = '0;
      mrdy_en[i] = 1'b0;
    end
  endtask

  // One clock cycle: compare at the falling edge, then advance the model past the rising edge.
  task automatic step();
    logic [11:0] rdy [2];
    logic [11:0] busy, drain [2];
    logic        free_all, exp_trdy;
    logic        acc [2];
    logic [95:0] word;
    logic [7:0]  td;
    @(negedge aclk);
    rdy[0] = a_rdy;
    rdy[1] = b_rdy;
    word   = s_tdata;
    for (int i = 0; i < 2; i++) begin
      busy     = '0;
      free_all = 1'b1;
      for (int n = 0; n < 12; n++) begin
        busy[n] = (lq[i*12+n].size() > 0);
        if (mmask[i][n] && busy[n] && !rdy[i][n]) free_all = 1'b0;
      end
      exp_trdy = mrdy_en[i] && free_all;
      check($sformatf("tready_%0d", i), (i == 0) ? a_trdy : b_trdy, exp_trdy);
      check($sformatf("busy_%0d", i), (i == 0) ? a_busy : b_busy, busy);
      check($sformatf("tvalid_%0d", i), (i == 0) ? a_tv : b_tv, busy);
      check($sformatf("count_%0d", i), (i == 0) ? a_cnt : {28'h0, b_cnt}, mcnt[i]);
      for (int n = 0; n < 12; n++) begin
        td = (i == 0) ? a_td[n] : b_td[n];
        if (!mmask[i][n]) check($sformatf("off_data_%0d_%0d", i, n), td, 8'h00);
        else if (busy[n]) check($sformatf("data_%0d_%0d", i, n), td, lq[i*12+n][0]);
      end
      acc[i]   = s_tvalid && exp_trdy;
      drain[i] = busy & rdy[i];
    end
    @(posedge aclk);
    #1;
    for (int i = 0; i < 2; i++) begin
      if (!aresetn) continue;
      for (int n = 0; n < 12; n++) begin
        if (drain[i][n]) void'(lq[i*12+n].pop_front());
        if (acc[i] && mmask[i][n]) lq[i*12+n].push_back(word[8*n +: 8]);
      end
      if (acc[i]) mcnt[i] = (mcnt[i] + 32'd1) & cmask[i];
      mrdy_en[i] = 1'b1;
    end
    if (!aresetn) model_clear();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    mmask[0] = 12'hFFF;
    mmask[1] = 12'h00F;
    cmask[0] = 32'hFFFF_FFFF;
    cmask[1] = 32'h0000_000F;
    model_clear();

    // Reset state, then first word one cycle after release.
    repeat (2) step();
    aresetn  = 1'b1;
    s_tvalid = 1'b1;
    s_tdata  = 96'h0B0A09080706050403020100;
    step();
    step();
    s_tvalid = 1'b0;
    check("first_valid", a_tv, 12'hFFF);
    check("first_lane5", a_td[5], 8'h05);
    check("first_lane11", a_td[11], 8'h0B);
    check("first_count", a_cnt, 32'd1);
    step();

    // Back-to-back stream, all lanes ready.
    s_tvalid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      s_tdata = {$urandom, $urandom, $urandom};
      step();
    end
    s_tvalid = 1'b0;
    check("stream_count", a_cnt, 32'd9);
    repeat (2) step();

    // Lane 5 stalls for four cycles.
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom, $urandom};
    step();
    a_rdy[5] = 1'b0;
    s_tdata  = {$urandom, $urandom, $urandom};
    step();
    check("stall_busy", a_busy, 12'h020);
    repeat (3) step();
    a_rdy[5] = 1'b1;
    step();
    s_tvalid = 1'b0;
    repeat (2) step();

    // Masked instance never stalls on its disabled lanes.
    b_rdy    = 12'h00F;
    s_tvalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      s_tdata = {$urandom, $urandom, $urandom};
      step();
    end
    s_tvalid = 1'b0;
    b_rdy    = 12'hFFF;
    repeat (2) step();

    // Asynchronous reset while every lane is stalled holding a byte.
    a_rdy    = 12'h000;
    b_rdy    = 12'h000;
    s_tvalid = 1'b1;
    s_tdata  = {$urandom, $urandom, $urandom};
    repeat (3) step();
    check("pre_reset_busy", a_busy, 12'hFFF);
    #2 aresetn = 1'b0;
    #1;
    check("async_tvalid_a", a_tv, 12'h000);
    check("async_tvalid_b", b_tv, 12'h000);
    check("async_count_a", a_cnt, 32'd0);
    check("async_busy_b", b_busy, 12'h000);
    model_clear();
    a_rdy    = 12'hFFF;
    b_rdy    = 12'hFFF;
    s_tvalid = 1'b0;
    step();
    aresetn = 1'b1;
    repeat (3) step();

    // Narrow counter wraps after sixteen accepts.
    s_tvalid = 1'b1;
    repeat (15) begin
      s_tdata = {$urandom, $urandom, $urandom};
      step();
    end
    check("wrap_pre", b_cnt, 4'hF);
    step();
    check("wrap_post", b_cnt, 4'h0);
    check("wide_no_wrap", a_cnt, 32'd16);

    // Randomized traffic and backpressure.
    for (int k = 0; k < 400; k++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      s_tdata  = {$urandom, $urandom, $urandom};
      a_rdy    = 12'($urandom | $urandom);
      b_rdy    = 12'($urandom | $urandom);
      step();
    end
    s_tvalid = 1'b0;
    a_rdy    = 12'hFFF;
    b_rdy    = 12'hFFF;
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
